// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder data-port responder.
// The MMIO addresses only decode when MEM_RESPONDER_MMIO_EN is defined.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_CYC,
        DEC_SCR,
        DEC_ERR
    } dec_t;

    localparam logic [31:0] MMIO_CYCLES_ADDR  = 32'hFFFF_FF00;
    localparam logic [31:0] MMIO_SCRATCH_ADDR = 32'hFFFF_FF04;

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous RAM, 32-bit words, no reset on contents.
// Read data is registered every clock from the presented index.
module resp_ram #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [DEPTH];

    // Write when enabled; always register the word at idx
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        rdata <= mem_q[idx];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store at a time, waits
// WAIT_CYCLES, then acks for one cycle with read data / error.
// Define MEM_RESPONDER_MMIO_EN to add the CYCLES and SCRATCH registers.
//
// Handshake: a request is taken on any clock edge where req=1 while the
// FSM is IDLE; we/addr/wdata are latched on that edge and may change
// afterwards. req is ignored in WAIT and RESP. ack is a one-cycle pulse
// with err and rdata valid alongside it; rdata then holds until the next ack.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output state_t      state_dbg
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] RAM_LIMIT = 32'(DEPTH * 4);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q;
    logic [31:0]      addr_q, wdata_q;
    logic [31:0]      rdata_q;
    logic [31:0]      resp_data;
    dec_t             dec;
    logic             ram_we;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_rdata;
    logic             accept;

    assign accept = (state_q == IDLE) && req;

    // FSM state and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE -> WAIT (or RESP with no wait states) -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the request fields on acceptance so the requester can move on
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Address decode on the latched address; misalignment wins over everything
    always_comb begin
        dec = DEC_ERR;
        if (addr_q[1:0] != 2'b00) begin
            dec = DEC_ERR;
        end else if (addr_q < RAM_LIMIT) begin
            dec = DEC_RAM;
        end
`ifdef MEM_RESPONDER_MMIO_EN
        else if (addr_q == MMIO_CYCLES_ADDR) begin
            dec = DEC_CYC;
        end else if (addr_q == MMIO_SCRATCH_ADDR) begin
            dec = DEC_SCR;
        end
`endif
    end

    // In IDLE the RAM looks at the incoming address so a zero-wait build
    // still reads on the acceptance edge; otherwise it uses the latched one.
    assign ram_idx = (state_q == IDLE) ? addr[IDX_W+1:2] : addr_q[IDX_W+1:2];
    assign ram_we  = (state_q == RESP) && we_q && (dec == DEC_RAM) && !rst;

    resp_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

`ifdef MEM_RESPONDER_MMIO_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_snap_q;
    logic [31:0] scratch_q;

    // Free-running cycle counter, snapshot taken on the edge into RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q      <= 32'd0;
            cyc_snap_q <= 32'd0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (state_d == RESP && state_q != RESP) begin
                cyc_snap_q <= cyc_q;
            end
        end
    end

    // Scratch register commits on the edge leaving RESP, like RAM stores
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q <= 32'd0;
        end else if (state_q == RESP && we_q && dec == DEC_SCR) begin
            scratch_q <= wdata_q;
        end
    end
`endif

    // Response data: loads select by decode, stores leave rdata untouched
    always_comb begin
        resp_data = rdata_q;
        if (!we_q) begin
            case (dec)
                DEC_RAM: resp_data = ram_rdata;
`ifdef MEM_RESPONDER_MMIO_EN
                DEC_CYC: resp_data = cyc_snap_q;
                DEC_SCR: resp_data = scratch_q;
`endif
                default: resp_data = 32'd0;
            endcase
        end
    end

    // Hold the last response so rdata stays stable between acks
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (state_q == RESP) begin
            rdata_q <= resp_data;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ack       = (state_q == RESP) && !rst;
    assign err       = ack && (dec == DEC_ERR);
    assign rdata     = (state_q == RESP) ? resp_data : rdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: instance 0 has WAIT_CYCLES=2,
// instance 1 has WAIT_CYCLES=0, both DEPTH=64.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic        busy_v  [2];
    logic        ack_v   [2];
    logic        err_v   [2];
    logic [31:0] rdata_v [2];
    state_t      st_v    [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .busy(busy_v[0]), .ack(ack_v[0]), .err(err_v[0]),
        .rdata(rdata_v[0]), .state_dbg(st_v[0])
    );

    mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .busy(busy_v[1]), .ack(ack_v[1]), .err(err_v[1]),
        .rdata(rdata_v[1]), .state_dbg(st_v[1])
    );

    // Driver: one transaction; returns acceptance cycle, latency to ack,
    // and err/rdata seen with ack. lat=-1 means no ack within the bound.
    task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int acc, output int lat, output logic e, output logic [31:0] rd);
        int i;
        e = 1'b0; rd = 32'd0; lat = -1; i = 0;
        @(negedge clk);
        acc = cyc;
        req_v[s] = 1'b1; we_v[s] = w; addr_v[s] = a; wdata_v[s] = d;
        @(posedge clk); #1;
        req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = $urandom; wdata_v[s] = $urandom;
        while (lat < 0 && i < 20) begin
            i++;
            @(negedge clk);
            if (ack_v[s]) begin
                lat = i; e = err_v[s]; rd = rdata_v[s];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_v[0] !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_v[0]); else n_pass++;
        n_checks++; if (ack_v[0] !== 1'b0) $display("FAIL rst_ack: got %b expected 0", ack_v[0]); else n_pass++;
        n_checks++; if (err_v[0] !== 1'b0) $display("FAIL rst_err: got %b expected 0", err_v[0]); else n_pass++;
        n_checks++; if (rdata_v[0] !== 32'd0) $display("FAIL rst_rdata: got %h expected 0", rdata_v[0]); else n_pass++;
        n_checks++; if (st_v[0] !== IDLE) $display("FAIL rst_state: got %0d expected %0d", st_v[0], IDLE); else n_pass++;
        n_checks++; if (rdata_v[1] !== 32'd0 || busy_v[1] !== 1'b0) $display("FAIL rst_b: got busy=%b rdata=%h expected 0/0", busy_v[1], rdata_v[1]); else n_pass++;
    endtask

    task automatic test_store_load();
        int acc, lat; logic e; logic [31:0] rd;
        xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, acc, lat, e, rd);
        n_checks++; if (lat !== 3) $display("FAIL st_lat: got %0d expected 3", lat); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL st_err: got %b expected 0", e); else n_pass++;
        xact(0, 1'b0, 32'h10, 32'h0, acc, lat, e, rd);
        n_checks++; if (lat !== 3) $display("FAIL ld_lat: got %0d expected 3", lat); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL ld_err: got %b expected 0", e); else n_pass++;
        n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ld_data: got %h expected deadbeef", rd); else n_pass++;
    endtask

    task automatic test_boundaries();
        int acc, lat; logic e; logic [31:0] rd;
        xact(0, 1'b0, 32'h3, 32'h0, acc, lat, e, rd);
        n_checks++; if (e !== 1'b1 || rd !== 32'd0) $display("FAIL misalign: got err=%b rdata=%h expected 1/0", e, rd); else n_pass++;
        xact(0, 1'b0, 32'h100, 32'h0, acc, lat, e, rd);
        n_checks++; if (e !== 1'b1) $display("FAIL past_end: got err=%b expected 1", e); else n_pass++;
        xact(0, 1'b0, 32'h10, 32'h0, acc, lat, e, rd);
        xact(0, 1'b1, 32'hFC, 32'h0BAD_F00D, acc, lat, e, rd);
        n_checks++; if (e !== 1'b0 || rd !== 32'hDEAD_BEEF) $display("FAIL st_top: got err=%b rdata=%h expected 0/deadbeef", e, rd); else n_pass++;
        xact(0, 1'b0, 32'hFC, 32'h0, acc, lat, e, rd);
        n_checks++; if (e !== 1'b0 || rd !== 32'h0BAD_F00D) $display("FAIL ld_top: got err=%b rdata=%h expected 0/0badf00d", e, rd); else n_pass++;
    endtask

    task automatic test_ignored_req();
        logic [15:0] amask, bmask;
        logic        ack_err;
        logic [31:0] ack_rd;
        amask = '0; bmask = '0;
        // Held request: acceptances every 4 cycles
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            amask[i] = ack_v[0];
            bmask[i] = busy_v[0];
        end
        req_v[0] = 1'b0;
        n_checks++; if (amask !== 16'h0888) $display("FAIL hold_ack: got %h expected 0888", amask); else n_pass++;
        n_checks++; if (bmask !== 16'h0EEE) $display("FAIL hold_busy: got %h expected 0eee", bmask); else n_pass++;
        // Pulses during WAIT and RESP must not start a transaction
        amask = '0; ack_err = 1'b1; ack_rd = 32'd0;
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 32'h10;
        @(posedge clk); #1;
        req_v[0] = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            amask[i] = ack_v[0];
            if (ack_v[0]) begin ack_err = err_v[0]; ack_rd = rdata_v[0]; end
            if (i == 1 || i == 3) begin
                req_v[0] = 1'b1; addr_v[0] = 32'h3;
            end else begin
                req_v[0] = 1'b0;
            end
        end
        n_checks++; if (amask !== 16'h0008) $display("FAIL pulse_ack: got %h expected 0008", amask); else n_pass++;
        n_checks++; if (ack_err !== 1'b0 || ack_rd !== 32'hDEAD_BEEF) $display("FAIL pulse_data: got err=%b rdata=%h expected 0/deadbeef", ack_err, ack_rd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acc, lat; logic e; logic [31:0] rd;
        xact(0, 1'b1, 32'h20, 32'h55AA_00FF, acc, lat, e, rd);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h1234_5678;
        @(posedge clk); #1;
        req_v[0] = 1'b0; we_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ack_v[0] !== 1'b0) $display("FAIL rmid_ack: got %b expected 0", ack_v[0]); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_v[0] !== 1'b0 || ack_v[0] !== 1'b0 || err_v[0] !== 1'b0 || rdata_v[0] !== 32'd0)
            $display("FAIL rmid_outs: got busy=%b ack=%b err=%b rdata=%h expected all 0", busy_v[0], ack_v[0], err_v[0], rdata_v[0]);
        else n_pass++;
        xact(0, 1'b0, 32'h20, 32'h0, acc, lat, e, rd);
        n_checks++; if (rd !== 32'h55AA_00FF) $display("FAIL rmid_keep: got %h expected 55aa00ff", rd); else n_pass++;
    endtask

    task automatic test_mmio();
        int acc, lat; logic e; logic [31:0] rd, rd1;
`ifdef MEM_RESPONDER_MMIO_EN
        xact(0, 1'b0, MMIO_CYCLES_ADDR, 32'h0, acc, lat, e, rd1);
        repeat (6) @(negedge clk);
        xact(0, 1'b0, MMIO_CYCLES_ADDR, 32'h0, acc, lat, e, rd);
        n_checks++; if (rd - rd1 !== 32'd10 || e !== 1'b0) $display("FAIL cyc_delta: got %0d err=%b expected 10/0", rd - rd1, e); else n_pass++;
        xact(0, 1'b1, MMIO_SCRATCH_ADDR, 32'hA5A5_A5A5, acc, lat, e, rd);
        n_checks++; if (e !== 1'b0) $display("FAIL scr_st_err: got %b expected 0", e); else n_pass++;
        xact(0, 1'b0, MMIO_SCRATCH_ADDR, 32'h0, acc, lat, e, rd);
        n_checks++; if (rd !== 32'hA5A5_A5A5) $display("FAIL scr_ld: got %h expected a5a5a5a5", rd); else n_pass++;
`else
        rd1 = 32'd0;
        xact(0, 1'b0, MMIO_CYCLES_ADDR, 32'h0, acc, lat, e, rd);
        n_checks++; if (e !== 1'b1 || rd !== rd1) $display("FAIL cyc_unmapped: got err=%b rdata=%h expected 1/0", e, rd); else n_pass++;
        xact(0, 1'b0, MMIO_SCRATCH_ADDR, 32'h0, acc, lat, e, rd);
        n_checks++; if (e !== 1'b1) $display("FAIL scr_unmapped: got err=%b expected 1", e); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, lat; logic e; logic [31:0] rd;
        xact(1, 1'b1, 32'h8, 32'hCAFE_F00D, acc1, lat, e, rd);
        n_checks++; if (lat !== 1 || e !== 1'b0) $display("FAIL w0_st: got lat=%0d err=%b expected 1/0", lat, e); else n_pass++;
        xact(1, 1'b0, 32'h8, 32'h0, acc2, lat, e, rd);
        n_checks++; if (acc2 - acc1 !== 2) $display("FAIL w0_gap: got %0d expected 2", acc2 - acc1); else n_pass++;
        n_checks++; if (lat !== 1 || rd !== 32'hCAFE_F00D) $display("FAIL w0_ld: got lat=%0d rdata=%h expected 1/cafef00d", lat, rd); else n_pass++;
        xact(1, 1'b0, 32'h200, 32'h0, acc2, lat, e, rd);
        n_checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'd0) $display("FAIL w0_err: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, e, rd); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_v[s] = 1'b0; we_v[s] = 1'b0; addr_v[s] = 32'd0; wdata_v[s] = 32'd0;
        end
        test_reset();
        test_store_load();
        test_boundaries();
        test_ignored_req();
        test_reset_mid();
        test_mmio();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's data port: accepts load/store requests (address, write data, write enable), serves them from a word-addressed RAM after a fixed number of wait states, and returns read data with a one-cycle acknowledge. Sits between the datapath's ALUResult/WriteData/ReadData signals and storage. Optionally also decodes a small MMIO region holding a cycle counter and a scratch register.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 2: wait states between request acceptance and response; 0..15.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only while idle.
- we  in  1  1 = store, 0 = load; sampled with req.
- addr  in  32  byte address; sampled with req.
- wdata  in  32  store data; sampled with req.
- busy  out  1  high from the cycle after acceptance through the ack cycle.
- ack  out  1  one-cycle response pulse.
- err  out  1  valid with ack; request was misaligned or unmapped.
- rdata  out  32  load data; valid with ack, held until the next ack.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if req=1, latch we/addr/wdata. Go to WAIT with wait counter = WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0.
- WAIT: decrement the counter. Go to RESP when it reaches 0.
- RESP: ack=1, then return to IDLE.
- req is ignored outside IDLE. No new request is accepted in the RESP cycle.
- Requester may drop req and the request fields after the acceptance edge.
- Decode on the latched address:
  - addr[1:0]≠0 → err.
  - addr < DEPTH*4 → RAM, word index addr[log2(DEPTH)+1:2].
  - MMIO addresses, with the macro only.
  - Anything else → err.
- Load: rdata is registered on the edge entering RESP. For err, rdata=0.
- Store: RAM write commits on the edge leaving RESP. No write on err. rdata is unchanged on stores.
- Read-after-write: a load accepted after a store's ack returns the stored value.
- Reset values: state=IDLE, busy=0, ack=0, err=0, rdata=0, wait counter=0. RAM contents are not reset.
- Reset mid-transaction: rst has priority in every state. The request is dropped with no ack. A store is suppressed even if rst asserts in its RESP cycle.

## Timing
- req=1 in IDLE at cycle c → ack=1 in cycle c+1+WAIT_CYCLES, for exactly one cycle.
- busy=1 in cycles c+1 … c+1+WAIT_CYCLES.
- Back-to-back requests: earliest next acceptance is cycle c+2+WAIT_CYCLES. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- The RAM is read synchronously at the edge into RESP. There is no combinational path from req/addr to any output.

## Configuration
- MEM_RESPONDER_MMIO_EN defined: the MMIO region decodes.
  - 0xFFFF_FF00: CYCLES. 32-bit free-running counter, reset 0, +1 every clock, wraps 0xFFFF_FFFF→0. Load returns its value in the cycle before ack. Store is ignored, err=0.
  - 0xFFFF_FF04: SCRATCH. 32-bit read/write, reset 0.
- Macro undefined: both addresses return err=1, and neither register exists.

## Structure
- Package mem_responder_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - localparams MMIO_CYCLES_ADDR=32'hFFFF_FF00 and MMIO_SCRATCH_ADDR=32'hFFFF_FF04;
  - the address-decode result enum (DEC_RAM/DEC_CYC/DEC_SCR/DEC_ERR).
- One sub-module, resp_ram: single-port synchronous RAM, parameter DEPTH, with we/idx/wdata/rdata ports and no reset.
- FSM, decode and MMIO logic live in mem_responder.

## Test plan
All with WAIT_CYCLES=2, DEPTH=64.
- Store then load: store 0xDEAD_BEEF to 0x10, then load 0x10 → ack exactly 3 cycles after each acceptance, err=0, rdata=0xDEAD_BEEF.
- Boundaries:
  - load 0x0000_0003 → err=1, rdata=0;
  - load 0x0000_0100 (index 64) → err=1;
  - store 0xFC → succeeds, readback matches.
- Ignored requests: hold req=1 continuously → acceptances every 4 cycles, busy=1 for 3 cycles each. A req pulse during WAIT is ignored.
- Reset mid-transaction:
  - store 0x1234_5678 to 0x20, assert rst in the RESP cycle → no ack, busy=0 next cycle;
  - a later load of 0x20 returns the previous contents;
  - all outputs are 0 after reset.
- MMIO with the macro:
  - two CYCLES loads accepted 10 cycles apart → values differ by 10;
  - SCRATCH store 0xA5A5_A5A5 then load → 0xA5A5_A5A5.
  - Without the macro: load 0xFFFF_FF00 → err=1.
- WAIT_CYCLES=0 build: ack in cycle c+1; a second request is accepted at c+2; back-to-back store/load on the same address returns the new data.
